// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute sequencer for the 8-bit CPU.
// Owns the program counter and instruction register, runs the shared memory
// req/ready handshake, and drives register-file selects and ALU controls.
`timescale 1ns/1ps
module multicycle_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  input  logic       mem_ready,
  input  logic [7:0] mem_rdata,
  output logic [1:0] rs1_sel,
  output logic [1:0] rs2_sel,
  input  logic [7:0] rs1_data,
  output logic [1:0] alu_op,
  output logic       alu_src_imm,
  output logic [1:0] immediate,
  input  logic [7:0] alu_result,
  output logic       reg_we,
  output logic       reg_wsrc,
  output logic [1:0] rd_sel,
  output logic [7:0] pc,
  output logic [7:0] ir,
  output logic       busy,
  output logic       halted,
  output logic       illegal
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [1:0] ALU_ADD  = 2'b00;

  logic [2:0] state;
  logic [2:0] state_nxt;

  logic [3:0] opcode;
  logic [1:0] fld_a;
  logic [1:0] fld_b;
  logic       is_alu;
  logic       is_addi;
  logic       is_lw;
  logic       is_sw;
  logic       is_bez;
  logic       is_halt;
  logic       is_ill;
  logic       is_mem;
  logic       restart;

  assign opcode  = ir[7:4];
  assign fld_a   = ir[3:2];
  assign fld_b   = ir[1:0];
  assign is_alu  = (opcode[3:2] == 2'b00);
  assign is_addi = (opcode == 4'b0011);
  assign is_lw   = (opcode == 4'b0100);
  assign is_sw   = (opcode == 4'b0101);
  assign is_bez  = (opcode == 4'b0110);
  assign is_halt = (opcode == 4'b0111);
  assign is_ill  = opcode[3];
  assign is_mem  = is_lw | is_sw;

  // start is only honoured from the two resting states
  assign restart = ((state == S_IDLE) || (state == S_HALT)) && start;

  // Next-state selection for the instruction sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_nxt = S_FETCH;
      S_FETCH:        if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_ill || is_halt) state_nxt = S_HALT;
        else if (is_bez)       state_nxt = S_FETCH;
        else                   state_nxt = S_EXEC;
      end
      S_EXEC:         state_nxt = is_mem ? S_MEM : S_WB;
      S_MEM:          if (mem_ready) state_nxt = is_lw ? S_WB : S_FETCH;
      S_WB:           state_nxt = S_FETCH;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Program counter: advance on fetch accept, extra advance on a taken BEZ skip
  always_ff @(posedge clk) begin
    if (reset)                                          pc <= RESET_PC;
    else if (restart)                                   pc <= RESET_PC;
    else if ((state == S_FETCH) && mem_ready)           pc <= pc + 8'd1;
    else if ((state == S_DECODE) && is_bez &&
             (rs1_data == 8'd0))                        pc <= pc + 8'd1;
  end

  // Instruction register loads the fetched byte when the memory accepts
  always_ff @(posedge clk) begin
    if (reset)                                pc_ir_clear();
    else if ((state == S_FETCH) && mem_ready) ir <= mem_rdata;
  end

  task automatic pc_ir_clear();
    ir <= 8'h00;
  endtask

  // Sticky illegal-opcode flag, cleared only by reset or a fresh start
  always_ff @(posedge clk) begin
    if (reset)                              illegal <= 1'b0;
    else if (restart)                       illegal <= 1'b0;
    else if ((state == S_DECODE) && is_ill) illegal <= 1'b1;
  end

  // Moore output decode from registered state and IR
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 8'h00;
    rs1_sel     = 2'b00;
    rs2_sel     = 2'b00;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    immediate   = 2'b00;
    reg_we      = 1'b0;
    reg_wsrc    = 1'b0;
    rd_sel      = 2'b00;
    busy        = (state != S_IDLE) && (state != S_HALT);
    halted      = (state == S_HALT);

    // Register selects stay valid from DECODE through WB so the ALU result
    // and store data remain stable for the whole instruction.
    if ((state == S_DECODE) || (state == S_EXEC) ||
        (state == S_MEM) || (state == S_WB)) begin
      if (is_mem) begin
        rs1_sel = fld_b;
        rs2_sel = fld_a;
      end else if (is_bez) begin
        rs1_sel = fld_a;
      end else if (is_alu) begin
        rs1_sel = fld_a;
        rs2_sel = fld_b;
      end
    end

    // ALU controls are held from EXEC through MEM and WB
    if ((state == S_EXEC) || (state == S_MEM) || (state == S_WB)) begin
      if (is_mem) begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b1;
        immediate   = 2'b00;
      end else if (is_alu) begin
        alu_op      = is_addi ? ALU_ADD : opcode[1:0];
        alu_src_imm = is_addi;
        immediate   = fld_b;
      end
    end

    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = is_sw;
        mem_addr = alu_result;
      end
      S_WB: begin
        reg_we   = 1'b1;
        reg_wsrc = is_lw;
        rd_sel   = fld_a;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: bench for multicycle_ctrl with a memory, register-file
// and ALU model around the controller and a scoreboard of memory accesses
// and register writes.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic       mem_ready;
  logic [7:0] mem_rdata;
  logic [1:0] rs1_sel;
  logic [1:0] rs2_sel;
  logic [7:0] rs1_data;
  logic [1:0] alu_op;
  logic       alu_src_imm;
  logic [1:0] immediate;
  logic [7:0] alu_result;
  logic       reg_we;
  logic       reg_wsrc;
  logic [1:0] rd_sel;
  logic [7:0] pc;
  logic [7:0] ir;
  logic       busy;
  logic       halted;
  logic       illegal;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rs1_data(rs1_data),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .immediate(immediate),
    .alu_result(alu_result),
    .reg_we(reg_we), .reg_wsrc(reg_wsrc), .rd_sel(rd_sel),
    .pc(pc), .ir(ir), .busy(busy), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // environment model
  logic [7:0]  mem [0:255];
  logic [7:0]  regs [0:3];
  logic [7:0]  rf_init [0:3];
  int          wait_tab [0:15];
  int          acc_idx;
  int          wcnt;
  int          cur_wait;
  logic [7:0]  lw_hold;
  logic [7:0]  op2;
  logic [7:0]  wdata;

  logic [16:0] obs_mem[$];
  logic [16:0] exp_mem[$];
  logic [10:0] obs_reg[$];
  logic [10:0] exp_reg[$];

  int n_checks = 0;
  int n_pass   = 0;

  assign cur_wait  = (acc_idx < 16) ? wait_tab[acc_idx[3:0]] : 0;
  assign mem_ready = mem_req && (wcnt >= cur_wait);
  assign mem_rdata = mem[mem_addr];
  assign rs1_data  = regs[rs1_sel];
  assign op2       = alu_src_imm ? {6'b0, immediate} : regs[rs2_sel];
  assign wdata     = reg_wsrc ? lw_hold : alu_result;

  always_comb begin
    alu_result = rs1_data & op2;
    case (alu_op)
      2'b00:   alu_result = rs1_data + op2;
      2'b01:   alu_result = rs1_data - op2;
      2'b10:   alu_result = rs1_data << op2;
      default: alu_result = rs1_data & op2;
    endcase
  end

  // observe accepted accesses and register writes; update register model
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= rf_init[i];
      acc_idx <= 0;
      wcnt    <= 0;
    end else begin
      if (mem_req && mem_ready) begin
        obs_mem.push_back({mem_we, mem_addr, (mem_we ? regs[rs2_sel] : mem_rdata)});
        acc_idx <= acc_idx + 1;
        lw_hold <= mem_rdata;
        wcnt    <= 0;
      end else if (mem_req) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt <= 0;
      end
      if (reg_we) begin
        obs_reg.push_back({rd_sel, reg_wsrc, wdata});
        regs[rd_sel] <= wdata;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic reset_dut(input logic [7:0] r0, input logic [7:0] r1,
                           input logic [7:0] r2, input logic [7:0] r3);
    rf_init[0] = r0; rf_init[1] = r1; rf_init[2] = r2; rf_init[3] = r3;
    for (int i = 0; i < 256; i++) mem[i] = 8'h70;
    for (int i = 0; i < 16; i++) wait_tab[i] = 0;
    reset = 1'b1;
    start = 1'b0;
    step();
    reset = 1'b0;
    obs_mem.delete(); obs_reg.delete(); exp_mem.delete(); exp_reg.delete();
  endtask

  task automatic test_reset();
    reset_dut(8'h00, 8'h00, 8'h00, 8'h00);
    n_checks++;
    if ({mem_req, mem_we, reg_we, busy, halted, illegal} !== 6'b0)
      $display("FAIL reset_strobes: got %b expected %b",
               {mem_req, mem_we, reg_we, busy, halted, illegal}, 6'b0);
    else n_pass++;
    n_checks++;
    if ({pc, ir} !== 16'h0000) $display("FAIL reset_pc_ir: got %h expected %h", {pc, ir}, 16'h0000);
    else n_pass++;
    n_checks++;
    if ({alu_op, alu_src_imm, immediate, rs1_sel, rs2_sel, rd_sel, reg_wsrc, mem_addr} !== 20'h0)
      $display("FAIL reset_ctrl: got %h expected %h",
               {alu_op, alu_src_imm, immediate, rs1_sel, rs2_sel, rd_sel, reg_wsrc, mem_addr}, 20'h0);
    else n_pass++;
  endtask

  task automatic test_addi_program();
    int we_cyc[$];
    int halt_cyc;
    int first_we;
    int second_we;
    logic ctl_ok;
    logic [16:0] e;
    logic [10:0] er;
    reset_dut(8'h00, 8'h00, 8'h00, 8'h00);
    mem[0] = 8'h31; mem[1] = 8'h31; mem[2] = 8'h70;
    exp_mem.push_back({1'b0, 8'h00, 8'h31});
    exp_mem.push_back({1'b0, 8'h01, 8'h31});
    exp_mem.push_back({1'b0, 8'h02, 8'h70});
    exp_reg.push_back({2'd0, 1'b0, 8'h01});
    exp_reg.push_back({2'd0, 1'b0, 8'h02});
    pulse_start();
    halt_cyc = 0;
    ctl_ok = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      if (reg_we === 1'b1) begin
        we_cyc.push_back(c);
        if (!(alu_src_imm === 1'b1 && rd_sel === 2'd0)) ctl_ok = 1'b0;
      end
      if (halted === 1'b1 && halt_cyc == 0) halt_cyc = c;
      step();
    end
    first_we  = (we_cyc.size() > 0) ? we_cyc[0] : -1;
    second_we = (we_cyc.size() > 1) ? we_cyc[1] : -1;
    n_checks++;
    if (we_cyc.size() != 2) $display("FAIL addi_we_count: got %0d expected %0d", we_cyc.size(), 2);
    else n_pass++;
    n_checks++;
    if (first_we != 4) $display("FAIL addi_we_first_cycle: got %0d expected %0d", first_we, 4);
    else n_pass++;
    n_checks++;
    if (second_we != 8) $display("FAIL addi_we_second_cycle: got %0d expected %0d", second_we, 8);
    else n_pass++;
    n_checks++;
    if (ctl_ok !== 1'b1) $display("FAIL addi_wb_controls: got %b expected %b", ctl_ok, 1'b1);
    else n_pass++;
    // program runs in cycles 1..10, HALT state is visible from cycle 11
    n_checks++;
    if (halt_cyc != 11) $display("FAIL addi_halt_cycle: got %0d expected %0d", halt_cyc, 11);
    else n_pass++;
    n_checks++;
    if (pc !== 8'h03) $display("FAIL addi_pc: got %h expected %h", pc, 8'h03);
    else n_pass++;
    while (exp_mem.size() > 0) begin
      e = exp_mem.pop_front();
      n_checks++;
      if (obs_mem.size() == 0) $display("FAIL addi_mem_seq: got none expected %h", e);
      else if (obs_mem[0] !== e) $display("FAIL addi_mem_seq: got %h expected %h", obs_mem.pop_front(), e);
      else begin void'(obs_mem.pop_front()); n_pass++; end
    end
    while (exp_reg.size() > 0) begin
      er = exp_reg.pop_front();
      n_checks++;
      if (obs_reg.size() == 0) $display("FAIL addi_reg_seq: got none expected %h", er);
      else if (obs_reg[0] !== er) $display("FAIL addi_reg_seq: got %h expected %h", obs_reg.pop_front(), er);
      else begin void'(obs_reg.pop_front()); n_pass++; end
    end
  endtask

  task automatic test_lw_wait();
    int hold_cnt;
    int wb_cyc;
    int nf_cyc;
    logic wb_src;
    logic [1:0] wb_rd;
    logic [1:0] dec_rs1;
    logic [16:0] e;
    logic [10:0] er;
    reset_dut(8'h00, 8'h20, 8'h00, 8'h00);
    mem[0] = 8'h41; mem[8'h20] = 8'h9C;
    wait_tab[1] = 3;
    exp_mem.push_back({1'b0, 8'h00, 8'h41});
    exp_mem.push_back({1'b0, 8'h20, 8'h9C});
    exp_mem.push_back({1'b0, 8'h01, 8'h70});
    exp_reg.push_back({2'd0, 1'b1, 8'h9C});
    pulse_start();
    hold_cnt = 0; wb_cyc = 0; nf_cyc = 0; wb_src = 1'b0; wb_rd = 2'd3; dec_rs1 = 2'd0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) dec_rs1 = rs1_sel;
      if (mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === 8'h20) hold_cnt++;
      if (reg_we === 1'b1 && wb_cyc == 0) begin
        wb_cyc = c; wb_src = reg_wsrc; wb_rd = rd_sel;
      end
      if (mem_req === 1'b1 && mem_addr === 8'h01 && nf_cyc == 0) nf_cyc = c;
      step();
    end
    n_checks++;
    if (dec_rs1 !== 2'd1) $display("FAIL lw_decode_rs1: got %0d expected %0d", dec_rs1, 1);
    else n_pass++;
    n_checks++;
    if (hold_cnt != 4) $display("FAIL lw_addr_hold: got %0d expected %0d", hold_cnt, 4);
    else n_pass++;
    n_checks++;
    if (wb_cyc != 8) $display("FAIL lw_wb_cycle: got %0d expected %0d", wb_cyc, 8);
    else n_pass++;
    n_checks++;
    if ({wb_src, wb_rd} !== 3'b100) $display("FAIL lw_wb_ctrl: got %b expected %b", {wb_src, wb_rd}, 3'b100);
    else n_pass++;
    n_checks++;
    if (nf_cyc != 9) $display("FAIL lw_next_fetch: got %0d expected %0d", nf_cyc, 9);
    else n_pass++;
    while (exp_mem.size() > 0) begin
      e = exp_mem.pop_front();
      n_checks++;
      if (obs_mem.size() == 0) $display("FAIL lw_mem_seq: got none expected %h", e);
      else if (obs_mem[0] !== e) $display("FAIL lw_mem_seq: got %h expected %h", obs_mem.pop_front(), e);
      else begin void'(obs_mem.pop_front()); n_pass++; end
    end
    while (exp_reg.size() > 0) begin
      er = exp_reg.pop_front();
      n_checks++;
      if (obs_reg.size() == 0) $display("FAIL lw_reg_seq: got none expected %h", er);
      else if (obs_reg[0] !== er) $display("FAIL lw_reg_seq: got %h expected %h", obs_reg.pop_front(), er);
      else begin void'(obs_reg.pop_front()); n_pass++; end
    end
  endtask

  task automatic test_sw();
    logic [11:0] c4;
    logic [9:0]  c5;
    int we_seen;
    logic [16:0] e;
    reset_dut(8'h00, 8'h5A, 8'h10, 8'h00);
    mem[0] = 8'h56;
    exp_mem.push_back({1'b0, 8'h00, 8'h56});
    exp_mem.push_back({1'b1, 8'h10, 8'h5A});
    exp_mem.push_back({1'b0, 8'h01, 8'h70});
    pulse_start();
    we_seen = 0; c4 = '0; c5 = '0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 4) c4 = {mem_req, mem_we, mem_addr, rs2_sel};
      if (c == 5) c5 = {mem_req, mem_we, mem_addr};
      if (reg_we === 1'b1) we_seen++;
      step();
    end
    n_checks++;
    if (c4 !== {1'b1, 1'b1, 8'h10, 2'd1}) $display("FAIL sw_mem_cycle: got %h expected %h", c4, {1'b1, 1'b1, 8'h10, 2'd1});
    else n_pass++;
    n_checks++;
    if (we_seen != 0) $display("FAIL sw_no_reg_we: got %0d expected %0d", we_seen, 0);
    else n_pass++;
    n_checks++;
    if (c5 !== {1'b1, 1'b0, 8'h01}) $display("FAIL sw_next_fetch: got %h expected %h", c5, {1'b1, 1'b0, 8'h01});
    else n_pass++;
    while (exp_mem.size() > 0) begin
      e = exp_mem.pop_front();
      n_checks++;
      if (obs_mem.size() == 0) $display("FAIL sw_mem_seq: got none expected %h", e);
      else if (obs_mem[0] !== e) $display("FAIL sw_mem_seq: got %h expected %h", obs_mem.pop_front(), e);
      else begin void'(obs_mem.pop_front()); n_pass++; end
    end
    n_checks++;
    if (obs_reg.size() != 0) $display("FAIL sw_reg_writes: got %0d expected %0d", obs_reg.size(), 0);
    else n_pass++;
  endtask

  task automatic test_bez();
    logic found;
    logic [16:0] e;
    // taken: R1 == 0 skips pc 1
    reset_dut(8'h00, 8'h00, 8'h00, 8'h00);
    mem[0] = 8'h64;
    exp_mem.push_back({1'b0, 8'h00, 8'h64});
    exp_mem.push_back({1'b0, 8'h02, 8'h70});
    pulse_start();
    step(); step();
    n_checks++;
    if ({pc, mem_req, mem_addr} !== {8'h02, 1'b1, 8'h02})
      $display("FAIL bez_taken: got %h expected %h", {pc, mem_req, mem_addr}, {8'h02, 1'b1, 8'h02});
    else n_pass++;
    step(); step(); step();
    while (exp_mem.size() > 0) begin
      e = exp_mem.pop_front();
      n_checks++;
      if (obs_mem.size() == 0) $display("FAIL bez_mem_seq: got none expected %h", e);
      else if (obs_mem[0] !== e) $display("FAIL bez_mem_seq: got %h expected %h", obs_mem.pop_front(), e);
      else begin void'(obs_mem.pop_front()); n_pass++; end
    end
    // not taken: R1 = 5
    reset_dut(8'h00, 8'h05, 8'h00, 8'h00);
    mem[0] = 8'h64;
    pulse_start();
    step(); step();
    n_checks++;
    if ({pc, mem_req, mem_addr} !== {8'h01, 1'b1, 8'h01})
      $display("FAIL bez_not_taken: got %h expected %h", {pc, mem_req, mem_addr}, {8'h01, 1'b1, 8'h01});
    else n_pass++;
    // taken skip at pc FE wraps to 00
    reset_dut(8'h00, 8'h00, 8'h01, 8'h00);
    for (int i = 0; i < 254; i++) mem[i] = 8'h68;
    mem[8'hFE] = 8'h64;
    pulse_start();
    found = 1'b0;
    for (int c = 0; c < 800 && !found; c++) begin
      if (mem_req === 1'b1 && mem_addr === 8'hFE) found = 1'b1;
      else step();
    end
    n_checks++;
    if (found !== 1'b1) $display("FAIL bez_reach_fe: got %b expected %b", found, 1'b1);
    else n_pass++;
    step(); step();
    n_checks++;
    if ({pc, mem_req, mem_addr} !== {8'h00, 1'b1, 8'h00})
      $display("FAIL bez_wrap: got %h expected %h", {pc, mem_req, mem_addr}, {8'h00, 1'b1, 8'h00});
    else n_pass++;
  endtask

  task automatic test_illegal();
    int req_after;
    logic [1:0] st3;
    logic [16:0] e;
    reset_dut(8'h00, 8'h00, 8'h00, 8'h00);
    mem[0] = 8'hA0;
    exp_mem.push_back({1'b0, 8'h00, 8'hA0});
    pulse_start();
    req_after = 0; st3 = 2'b00;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1 && mem_req === 1'b1) req_after++;
      if (c == 3) st3 = {illegal, halted};
      step();
    end
    n_checks++;
    if (st3 !== 2'b11) $display("FAIL illegal_flags: got %b expected %b", st3, 2'b11);
    else n_pass++;
    n_checks++;
    if (req_after != 0) $display("FAIL illegal_no_access: got %0d expected %0d", req_after, 0);
    else n_pass++;
    n_checks++;
    if (illegal !== 1'b1) $display("FAIL illegal_sticky: got %b expected %b", illegal, 1'b1);
    else n_pass++;
    while (exp_mem.size() > 0) begin
      e = exp_mem.pop_front();
      n_checks++;
      if (obs_mem.size() == 0) $display("FAIL illegal_mem_seq: got none expected %h", e);
      else if (obs_mem[0] !== e) $display("FAIL illegal_mem_seq: got %h expected %h", obs_mem.pop_front(), e);
      else begin void'(obs_mem.pop_front()); n_pass++; end
    end
    pulse_start();
    n_checks++;
    if ({illegal, halted, busy, mem_req, pc, mem_addr} !== {4'b0011, 8'h00, 8'h00})
      $display("FAIL illegal_restart: got %h expected %h",
               {illegal, halted, busy, mem_req, pc, mem_addr}, {4'b0011, 8'h00, 8'h00});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    reset_dut(8'h00, 8'h00, 8'h00, 8'h00);
    mem[0] = 8'h31;
    wait_tab[1] = 20;
    pulse_start();
    for (int c = 1; c < 6; c++) step();
    n_checks++;
    if ({mem_req, busy, pc, mem_addr} !== {2'b11, 8'h01, 8'h01})
      $display("FAIL midreset_pre: got %h expected %h", {mem_req, busy, pc, mem_addr}, {2'b11, 8'h01, 8'h01});
    else n_pass++;
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    n_checks++;
    if ({mem_req, busy, halted, pc, ir} !== {3'b000, 8'h00, 8'h00})
      $display("FAIL midreset_post: got %h expected %h", {mem_req, busy, halted, pc, ir}, {3'b000, 8'h00, 8'h00});
    else n_pass++;
    step();
    n_checks++;
    if ({mem_req, busy} !== 2'b00) $display("FAIL midreset_reset_wins: got %b expected %b", {mem_req, busy}, 2'b00);
    else n_pass++;
  endtask

  task automatic test_start_busy();
    reset_dut(8'h00, 8'h00, 8'h00, 8'h00);
    mem[0] = 8'h31;
    pulse_start();
    step(); step();
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({reg_we, pc} !== {1'b1, 8'h01}) $display("FAIL start_busy_wb: got %h expected %h", {reg_we, pc}, {1'b1, 8'h01});
    else n_pass++;
    step();
    n_checks++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h01})
      $display("FAIL start_busy_fetch: got %h expected %h", {mem_req, mem_addr}, {1'b1, 8'h01});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_addi_program();
    test_lw_wait();
    test_sw();
    test_bez();
    test_illegal();
    test_reset_mid();
    test_start_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
